// File: rtl/apb_ram_ws.sv
// APB slave RAM with byte strobes, programmable wait states and an out-of-range error.
// Storage is split into one 8-bit lane per byte strobe; the lanes are not reset.

module apb_ram_ws_lane #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             gclk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [7:0]       wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [7:0]       rdata
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge gclk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

module apb_ram_ws #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 5,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                PSEL,
  input  logic [ADDR_W-1:0]   PADDR,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [DATA_W-1:0]   PWDATA,
  input  logic [DATA_W/8-1:0] PSTRB,
  output logic [DATA_W-1:0]   PRDATA,
  output logic                PREADY,
  output logic                PSLVERR
);
  localparam int NUM_LANES = DATA_W / 8;
  localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DATA_W % 8 != 0 || DATA_W < 8) begin : g_bad_data_w
    $error("apb_ram_ws: DATA_W must be a non-zero multiple of 8");
  end
  if (DEPTH < 1 || DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
    $error("apb_ram_ws: DEPTH must be in 1..2^ADDR_W");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_ws
    $error("apb_ram_ws: WAIT_STATES must be in 0..15");
  end

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                        state;
  logic [3:0]                    cnt;
  logic [IDX_W-1:0]              addr_q;
  logic                          wr_q, rng_q;
  logic                          in_range, we;
  logic [IDX_W-1:0]              idx;
  logic [NUM_LANES-1:0][7:0]     rd_lanes;
  logic [NUM_LANES-1:0][7:0]     wd_lanes;
  logic [NUM_LANES-1:0]          we_lane;

  assign in_range = 32'(PADDR) < 32'(DEPTH);
  assign idx      = PADDR[IDX_W-1:0];
  assign wd_lanes = PWDATA;
  // Commit only while the master still holds the access phase; an abort or reset drops it.
  assign we       = (state == DONE) && PSEL && PENABLE && wr_q && rng_q;
  assign we_lane  = {NUM_LANES{we}} & PSTRB;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    apb_ram_ws_lane #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_lane (
      .gclk  (PCLK),
      .we    (we_lane[i]),
      .waddr (addr_q),
      .wdata (wd_lanes[i]),
      .raddr (idx),
      .rdata (rd_lanes[i])
    );
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      rng_q   <= 1'b0;
      PRDATA  <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
          if (PSEL && !PENABLE) begin
            PRDATA <= in_range ? DATA_W'(rd_lanes) : '0;
            addr_q <= idx;
            wr_q   <= PWRITE;
            rng_q  <= in_range;
            cnt    <= 4'(WAIT_STATES);
            if (WAIT_STATES > 0) state <= WAIT;
            else begin
              state   <= DONE;
              PREADY  <= 1'b1;
              PSLVERR <= !in_range;
            end
          end
        end
        WAIT: begin
          if (!PSEL) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (PENABLE) begin
            if (cnt <= 4'd1) begin
              cnt     <= '0;
              state   <= DONE;
              PREADY  <= 1'b1;
              PSLVERR <= !rng_q;
            end else cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state   <= IDLE;
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_ram_ws.sv
// Directed bench: three RAM flavours share one APB driver; sel picks the active slave.

module tb_apb_ram_ws;
  logic        pclk = 1'b0;
  logic        presetn;
  logic        psel, penable, pwrite;
  logic [4:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  int          sel;

  logic [7:0]  prdata_a, prdata_c;
  logic [31:0] prdata_b;
  logic        pready_a, pready_b, pready_c;
  logic        pslverr_a, pslverr_b, pslverr_c;
  logic [31:0] rdata;
  logic        ready, slverr;

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  // A: legacy drop-in, B: 32-bit / 12 words / 2 waits, C: 3 waits
  apb_ram_ws #(.DATA_W(8), .ADDR_W(5), .DEPTH(16), .WAIT_STATES(0)) u_a (
    .PCLK(pclk), .PRESETn(presetn), .PSEL(psel && sel == 0), .PADDR(paddr),
    .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata[7:0]), .PSTRB(pstrb[0:0]),
    .PRDATA(prdata_a), .PREADY(pready_a), .PSLVERR(pslverr_a));

  apb_ram_ws #(.DATA_W(32), .ADDR_W(4), .DEPTH(12), .WAIT_STATES(2)) u_b (
    .PCLK(pclk), .PRESETn(presetn), .PSEL(psel && sel == 1), .PADDR(paddr[3:0]),
    .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata_b), .PREADY(pready_b), .PSLVERR(pslverr_b));

  apb_ram_ws #(.DATA_W(8), .ADDR_W(5), .DEPTH(16), .WAIT_STATES(3)) u_c (
    .PCLK(pclk), .PRESETn(presetn), .PSEL(psel && sel == 2), .PADDR(paddr),
    .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata[7:0]), .PSTRB(pstrb[0:0]),
    .PRDATA(prdata_c), .PREADY(pready_c), .PSLVERR(pslverr_c));

  assign rdata  = (sel == 0) ? {24'b0, prdata_a} : (sel == 1) ? prdata_b : {24'b0, prdata_c};
  assign ready  = (sel == 0) ? pready_a  : (sel == 1) ? pready_b  : pready_c;
  assign slverr = (sel == 0) ? pslverr_a : (sel == 1) ? pslverr_b : pslverr_c;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge pclk); #1; end
  endtask

  // Entered and left at #1 after a rising edge, so consecutive calls are back-to-back.
  task automatic xfer(input logic wr, input logic [4:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output int cyc,
                      output logic err);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(posedge pclk); #1;
    penable = 1'b1;
    cyc = 1;
    while (!ready && cyc < 40) begin
      @(posedge pclk); #1;
      cyc++;
    end
    rd  = rdata;
    err = slverr;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wr_chk(input string tag, input logic [4:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int exp_cyc, input logic exp_err);
    logic [31:0] rd;
    int          cyc;
    logic        err;
    xfer(1'b1, a, d, s, rd, cyc, err);
    chk({tag, "_cyc"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp_d,
                        input int exp_cyc, input logic exp_err);
    logic [31:0] rd;
    int          cyc;
    logic        err;
    xfer(1'b0, a, 32'h0, 4'h0, rd, cyc, err);
    chk({tag, "_cyc"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_dat"}, rd, exp_d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; sel = 0;
    idle(2);
    chk("rst_rdy_a", 32'(pready_a), 0);
    chk("rst_rdy_b", 32'(pready_b), 0);
    chk("rst_rdy_c", 32'(pready_c), 0);
    chk("rst_err_a", 32'(pslverr_a), 0);
    chk("rst_err_b", 32'(pslverr_b), 0);
    chk("rst_err_c", 32'(pslverr_c), 0);
    chk("rst_prd_a", 32'(prdata_a), 0);
    chk("rst_prd_b", prdata_b, 0);
    chk("rst_prd_c", 32'(prdata_c), 0);
    presetn = 1'b1;
    idle(2);

    // zero-wait legacy flavour
    sel = 0;
    wr_chk("a_w3", 5'd3, 32'hA5, 4'h1, 1, 1'b0);
    chk("a_drop", 32'(ready), 0);
    idle(2);
    rd_chk("a_r3", 5'd3, 32'hA5, 1, 1'b0);
    idle(1);
    wr_chk("a_w7", 5'd7, 32'h77, 4'h1, 1, 1'b0);
    rd_chk("a_b2b_r7", 5'd7, 32'h77, 1, 1'b0);

    // byte strobes and wait states
    sel = 1;
    wr_chk("b_w5_full", 5'd5, 32'h11223344, 4'hF, 3, 1'b0);
    wr_chk("b_w5_strb", 5'd5, 32'hAABBCCDD, 4'b0101, 3, 1'b0);
    rd_chk("b_r5", 5'd5, 32'h11BB33DD, 3, 1'b0);
    wr_chk("b_w5_nostrb", 5'd5, 32'hFFFFFFFF, 4'h0, 3, 1'b0);
    rd_chk("b_r5_keep", 5'd5, 32'h11BB33DD, 3, 1'b0);
    idle(1);
    wr_chk("b_w1", 5'd1, 32'h0000005A, 4'hF, 3, 1'b0);
    rd_chk("b_r1", 5'd1, 32'h0000005A, 3, 1'b0);

    // out-of-range accesses
    wr_chk("b_w11", 5'd11, 32'hCAFE0011, 4'hF, 3, 1'b0);
    wr_chk("b_w12_oor", 5'd12, 32'hDEADBEEF, 4'hF, 3, 1'b1);
    wr_chk("b_w13_oor", 5'd13, 32'hDEADBEEF, 4'hF, 3, 1'b1);
    rd_chk("b_r13_oor", 5'd13, 32'h0, 3, 1'b1);
    rd_chk("b_r11", 5'd11, 32'hCAFE0011, 3, 1'b0);
    rd_chk("b_r5_oor_keep", 5'd5, 32'h11BB33DD, 3, 1'b0);

    // master drops PSEL mid-wait: no PREADY, no write
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'd11;
    pwdata = 32'h12345678; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    chk("b_abort_rdy0", 32'(ready), 0);
    @(posedge pclk); #1;
    chk("b_abort_rdy1", 32'(ready), 0);
    rd_chk("b_abort_r11", 5'd11, 32'hCAFE0011, 3, 1'b0);

    // reset during the second wait cycle of a write
    sel = 2;
    idle(1);
    wr_chk("c_w2", 5'd2, 32'h33, 4'h1, 4, 1'b0);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'd2;
    pwdata = 32'hFF; pstrb = 4'h1;
    @(posedge pclk); #1;
    penable = 1'b1;
    chk("c_wait1_rdy", 32'(ready), 0);
    @(posedge pclk); #1;
    chk("c_wait2_prd", rdata, 32'h33);
    presetn = 1'b0;
    #1;
    chk("c_arst_rdy", 32'(ready), 0);
    chk("c_arst_err", 32'(slverr), 0);
    chk("c_arst_prd", rdata, 0);
    psel = 1'b0; penable = 1'b0;
    idle(2);
    presetn = 1'b1;
    idle(1);
    rd_chk("c_r2_after_rst", 5'd2, 32'h33, 4, 1'b0);
    sel = 1;
    rd_chk("b_r5_after_rst", 5'd5, 32'h11BB33DD, 3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
